quad_sample_scheduler: RTL

//  Owns the oe/we/data bus of one quadrature decoder and shares it between a CPU port and an internal periodic sampler.
//  The sampler reads the position counter every SAMPLE_CYCLES clocks and publishes a signed velocity (delta per period).
//  CPU reads and writes (position preset) are serialised against the sampler; sits between the decoder and the CPU bus.

---
 rtl/quad_sample_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/quad_sample_scheduler.sv
// Shares one quadrature decoder's oe/we/data bus between CPU reads/presets and a periodic velocity sampler.
// Define QSS_VEL_CLAMP_EN to clamp the published velocity to +/-VEL_LIMIT and report clamping on vel_clamp.
module quad_sample_scheduler #(
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned SAMPLE_CYCLES = 1000,
  parameter int unsigned VEL_LIMIT     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_req,
  input  logic                 cpu_wr,
  input  logic [BUS_WIDTH-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [BUS_WIDTH-1:0] cpu_rdata,
  output logic                 qd_oe,
  output logic                 qd_we,
  output logic                 qd_drive,
  output logic [BUS_WIDTH-1:0] qd_wdata,
  input  logic [BUS_WIDTH-1:0] qd_rdata,
  output logic [BUS_WIDTH-1:0] velocity,
  output logic                 vel_valid,
  output logic                 vel_clamp
);

`ifdef QSS_VEL_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [BUS_WIDTH-1:0]        TIMER_RELOAD = BUS_WIDTH'(SAMPLE_CYCLES - 1);
  localparam logic signed [BUS_WIDTH-1:0] LIM_POS      = BUS_WIDTH'(VEL_LIMIT);
  localparam logic signed [BUS_WIDTH-1:0] LIM_NEG      = -LIM_POS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SMP_OE  = 3'd1,
    S_SMP_CAP = 3'd2,
    S_CPU_OE  = 3'd3,
    S_CPU_CAP = 3'd4,
    S_CPU_WR  = 3'd5
  } state_t;

  state_t               r_state;
  logic [BUS_WIDTH-1:0] r_timer;
  logic                 r_smp_pend;
  logic [BUS_WIDTH-1:0] r_prev;
  logic                 r_cpu_ack;
  logic [BUS_WIDTH-1:0] r_cpu_rdata;
  logic                 r_qd_oe;
  logic                 r_qd_we;
  logic                 r_qd_drive;
  logic [BUS_WIDTH-1:0] r_qd_wdata;
  logic [BUS_WIDTH-1:0] r_velocity;
  logic                 r_vel_valid;
  logic                 r_vel_clamp;

  logic                 w_tick;
  logic                 w_pend_clr;
  logic [BUS_WIDTH-1:0] w_delta;
  logic [BUS_WIDTH-1:0] w_vel_next;
  logic                 w_clamp_next;

  assign w_tick     = (r_timer == '0);
  assign w_pend_clr = (r_state == S_SMP_OE);
  assign w_delta    = qd_rdata - r_prev;

  // Free-running sample timer; a new tick wins over the clear so no period is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer    <= TIMER_RELOAD;
      r_smp_pend <= 1'b0;
    end else begin
      if (w_tick) begin
        r_timer    <= TIMER_RELOAD;
        r_smp_pend <= 1'b1;
      end else begin
        r_timer <= r_timer - BUS_WIDTH'(1);
        if (w_pend_clr) begin
          r_smp_pend <= 1'b0;
        end
      end
    end
  end

  // Signed saturation of the period delta; folds away when clamping is disabled.
  always_comb begin
    w_vel_next   = w_delta;
    w_clamp_next = 1'b0;
    if (CLAMP_EN) begin
      if ($signed(w_delta) > LIM_POS) begin
        w_vel_next   = LIM_POS;
        w_clamp_next = 1'b1;
      end else if ($signed(w_delta) < LIM_NEG) begin
        w_vel_next   = LIM_NEG;
        w_clamp_next = 1'b1;
      end
    end
  end

  // Bus arbiter; bus controls are registered on entry so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_qd_oe     <= 1'b0;
      r_qd_we     <= 1'b0;
      r_qd_drive  <= 1'b0;
      r_qd_wdata  <= '0;
      r_velocity  <= '0;
      r_vel_valid <= 1'b0;
      r_vel_clamp <= 1'b0;
    end else begin
      r_cpu_ack   <= 1'b0;
      r_vel_valid <= 1'b0;
      r_qd_oe     <= 1'b0;
      r_qd_we     <= 1'b0;
      r_qd_drive  <= 1'b0;
      r_qd_wdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (r_smp_pend) begin
            r_state <= S_SMP_OE;
            r_qd_oe <= 1'b1;
          end else if (cpu_req && cpu_wr) begin
            r_state    <= S_CPU_WR;
            r_qd_we    <= 1'b1;
            r_qd_drive <= 1'b1;
            r_qd_wdata <= cpu_wdata;
          end else if (cpu_req) begin
            r_state <= S_CPU_OE;
            r_qd_oe <= 1'b1;
          end
        end
        S_SMP_OE: begin
          r_state <= S_SMP_CAP;
          r_qd_oe <= 1'b1;
        end
        S_SMP_CAP: begin
          r_state     <= S_IDLE;
          r_velocity  <= w_vel_next;
          r_vel_clamp <= w_clamp_next;
          r_vel_valid <= 1'b1;
          r_prev      <= qd_rdata;
        end
        S_CPU_OE: begin
          r_state <= S_CPU_CAP;
          r_qd_oe <= 1'b1;
        end
        S_CPU_CAP: begin
          r_state     <= S_IDLE;
          r_cpu_rdata <= qd_rdata;
          r_cpu_ack   <= 1'b1;
        end
        S_CPU_WR: begin
          // Rebase on the preset so the next velocity carries no step.
          r_state   <= S_IDLE;
          r_prev    <= cpu_wdata;
          r_cpu_ack <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign qd_oe     = r_qd_oe;
  assign qd_we     = r_qd_we;
  assign qd_drive  = r_qd_drive;
  assign qd_wdata  = r_qd_wdata;
  assign velocity  = r_velocity;
  assign vel_valid = r_vel_valid;
  assign vel_clamp = r_vel_clamp;

endmodule
